// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M/RV64M multiply/divide unit
// Single outstanding op: pipelined multiply, restoring radix-2^DIV_BITS divide, flush abort.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int NDIV = XLEN / DIV_BITS;
  localparam int CMAX = (NDIV > MUL_STAGES) ? NDIV : MUL_STAGES;
  localparam int CW   = $clog2(CMAX + 1);

  generate
    if ((XLEN % DIV_BITS) != 0 || MUL_STAGES < 1) begin : g_param_check
      $error("muldiv_unit: XLEN must be a multiple of DIV_BITS and MUL_STAGES >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_prod;
  logic                r_mul_hi;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_dvs;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_is_rem;
  logic                r_out_valid;
  logic [XLEN-1:0]     r_out_result;

  logic                w_accept;
  logic                w_sgn_div, w_neg1, w_neg2;
  logic [XLEN-1:0]     w_abs1, w_abs2, w_min;
  logic                w_div0, w_ovf, w_special;
  logic [XLEN-1:0]     w_special_res;
  logic                w_a_sgn, w_b_sgn;
  logic [2*XLEN-1:0]   w_a_wide, w_b_wide, w_prod;
  logic [XLEN-1:0]     w_st_rem, w_st_quo, w_st_dvs;
  logic [XLEN-1:0]     w_rem_n, w_quo_n;
  logic [XLEN:0]       w_sh, w_diff;
  logic [XLEN-1:0]     w_q_fix, w_r_fix;

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;

  assign w_accept  = in_valid && (r_state == S_IDLE) && !flush;

  // Signed divide ops are DIV (100) and REM (110).
  assign w_sgn_div = op[2] & ~op[0];
  assign w_neg1    = w_sgn_div & src1[XLEN-1];
  assign w_neg2    = w_sgn_div & src2[XLEN-1];
  assign w_abs1    = w_neg1 ? -src1 : src1;
  assign w_abs2    = w_neg2 ? -src2 : src2;
  assign w_min     = {1'b1, {(XLEN-1){1'b0}}};
  assign w_div0    = (src2 == '0);
  assign w_ovf     = w_sgn_div && (src1 == w_min) && (src2 == '1);
  assign w_special = w_div0 | w_ovf;
  assign w_special_res = w_div0 ? (op[1] ? src1 : '1) : (op[1] ? '0 : src1);

  // MULH: s x s, MULHSU: s x u, MUL/MULHU: u x u; low 2*XLEN bits of the
  // extended product are exact for every signedness combination.
  assign w_a_sgn  = op[0] ^ op[1];
  assign w_b_sgn  = op[0] & ~op[1];
  assign w_a_wide = {{XLEN{w_a_sgn & src1[XLEN-1]}}, src1};
  assign w_b_wide = {{XLEN{w_b_sgn & src2[XLEN-1]}}, src2};
  assign w_prod   = w_a_wide * w_b_wide;

  // The first divide step runs on the accept edge so the last one can hand off to FIX in time.
  assign w_st_rem = (r_state == S_IDLE) ? '0     : r_rem;
  assign w_st_quo = (r_state == S_IDLE) ? w_abs1 : r_quo;
  assign w_st_dvs = (r_state == S_IDLE) ? w_abs2 : r_dvs;

  always_comb begin
    w_rem_n = w_st_rem;
    w_quo_n = w_st_quo;
    w_sh    = '0;
    w_diff  = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      w_sh    = {w_rem_n, w_quo_n[XLEN-1]};
      w_quo_n = {w_quo_n[XLEN-2:0], 1'b0};
      w_diff  = w_sh - {1'b0, w_st_dvs};
      if (!w_diff[XLEN]) begin
        w_rem_n    = w_diff[XLEN-1:0];
        w_quo_n[0] = 1'b1;
      end else begin
        w_rem_n = w_sh[XLEN-1:0];
      end
    end
  end

  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_prod       <= '0;
      r_mul_hi     <= 1'b0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_dvs        <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_is_rem     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else if (flush && r_state != S_IDLE) begin
      r_state      <= S_IDLE;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!op[2]) begin
              r_prod   <= w_prod;
              r_mul_hi <= (op[1:0] != 2'b00);
              if (MUL_STAGES == 1) begin
                r_state      <= S_DONE;
                r_out_valid  <= 1'b1;
                r_out_result <= (op[1:0] != 2'b00) ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
              end else begin
                r_state <= S_MUL;
                r_cnt   <= CW'(MUL_STAGES - 1);
              end
            end else if (w_special) begin
              r_state      <= S_DONE;
              r_out_valid  <= 1'b1;
              r_out_result <= w_special_res;
            end else begin
              r_state  <= S_DIV;
              r_rem    <= w_rem_n;
              r_quo    <= w_quo_n;
              r_dvs    <= w_abs2;
              r_neg_q  <= w_neg1 ^ w_neg2;
              r_neg_r  <= w_neg1;
              r_is_rem <= op[1];
              r_cnt    <= CW'(NDIV - 1);
            end
          end
        end
        S_MUL: begin
          if (r_cnt == CW'(1)) begin
            r_state      <= S_DONE;
            r_out_valid  <= 1'b1;
            r_out_result <= r_mul_hi ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DIV: begin
          r_rem <= w_rem_n;
          r_quo <= w_quo_n;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state      <= S_DONE;
          r_out_valid  <= 1'b1;
          r_out_result <= r_is_rem ? w_r_fix : w_q_fix;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state      <= S_IDLE;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (32-bit default and 64-bit radix-16)
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, busy;
  logic [2:0]  op;
  logic [31:0] src1, src2, out_result;

  logic        rst_w, in_valid_w, flush_w, out_ready_w;
  logic        in_ready_w, out_valid_w, busy_w;
  logic [2:0]  op_w;
  logic [63:0] src1_w, src2_w, out_result_w;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q_exp[$];
  int          q_lat[$];

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
  );

  muldiv_unit #(.XLEN(64), .MUL_STAGES(2), .DIV_BITS(4)) dut_w (
    .clk(clk), .rst(rst_w), .flush(flush_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .op(op_w), .src1(src1_w), .src2(src2_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out_result(out_result_w), .busy(busy_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] ax, bx;
    logic signed [65:0] p;
    logic               ovf;
    ax  = {((o == 3'd1) || (o == 3'd2)) & a[31], a};
    bx  = {(o == 3'd1) & b[31], b};
    p   = ax * bx;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0:    return p[31:0];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      3'd7:    return (b == 0) ? a : a % b;
      default: return p[63:32];
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int hold, input string tag);
    int          k;
    logic [31:0] e;
    q_exp.push_back(exp);
    q_lat.push_back(lat);
    out_ready = (hold == 0);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); src1 = $urandom; src2 = $urandom;
    k = 1;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    e = q_exp.pop_front();
    check({tag, " latency"}, 64'(k), 64'(q_lat.pop_front()));
    check(tag, 64'(out_result), 64'(e));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held result"}, 64'(out_result), 64'(e));
      check({tag, " held in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    int          lat, k, seen;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; src1 = '0; src2 = '0;
    rst_w = 1'b1; flush_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b1; op_w = '0;
    src1_w = '0; src2_w = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst_w = 1'b0;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_result", 64'(out_result), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);

    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0, "MULH min*min");
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2, 0, "MUL min*min");
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, "MULHSU -1*max");
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "DIV -7/2");
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "REM -7/2");
    issue(3'd5, 32'd100, 32'd7, 32'd14, 33, 0, "DIVU 100/7");
    issue(3'd7, 32'd100, 32'd7, 32'd2, 33, 0, "REMU 100/7");
    issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "DIVU 5/0");
    issue(3'd6, 32'd5, 32'd0, 32'd5, 1, 0, "REM 5/0");
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "DIV overflow");
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "REM overflow");

    // Flush a divide mid-flight: unit idles immediately and never produces it.
    op = 3'd4; src1 = 32'd1000; src2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("flush no output", 64'(seen), 64'd0);
    issue(3'd0, 32'd6, 32'd7, 32'd42, 2, 0, "MUL after flush");

    // Flush in IDLE with a request: not accepted.
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; src1 = 32'd3; src2 = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("idle flush busy", 64'(busy), 64'd0);

    issue(3'd5, 32'd9, 32'd3, 32'd3, 33, 5, "DIVU 9/3 backpressure");

    for (int n = 0; n < 16; n++) begin
      o = 3'(n % 8);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (n == 12) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (!o[2]) lat = 2;
      else if (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 1;
      else lat = 33;
      issue(o, a, b, model(o, a, b), lat, 0, $sformatf("rand op%0d %0h/%0h", o, a, b));
    end

    // 64-bit radix-16 instance.
    check("wide reset in_ready", 64'(in_ready_w), 64'd1);
    op_w = 3'd5; src1_w = 64'h8000_0000_0000_0000; src2_w = 64'd3; in_valid_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0; src1_w = '1;
    k = 1;
    while (!out_valid_w && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("wide DIVU latency", 64'(k), 64'd17);
    check("wide DIVU 2^63/3", out_result_w, 64'h2AAA_AAAA_AAAA_AAAA);
    @(posedge clk); #1;
    check("wide idle", 64'(in_ready_w), 64'd1);

    op_w = 3'd5; src1_w = 64'h8000_0000_0000_0000; src2_w = 64'd3; in_valid_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_w = 1'b1;
    @(posedge clk); #1;
    rst_w = 1'b0;
    check("wide rst out_valid", 64'(out_valid_w), 64'd0);
    check("wide rst out_result", out_result_w, 64'd0);
    check("wide rst busy", 64'(busy_w), 64'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid_w) seen++;
      @(posedge clk); #1;
    end
    check("wide rst no output", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle M-extension execution unit: all eight RV32M/RV64M ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the combinational ALU in EX; the pipeline stalls on in_ready/out_valid.
- Adds pipelined multiply, iterative radix-2^k division with spec-exact corner cases, and flush abort.
- Single outstanding operation.

Parameters:
- XLEN, 32: operand/result width; 32 or 64.
- MUL_STAGES, 2: multiply latency in cycles, ≥1.
- DIV_BITS, 1: quotient bits retired per divide cycle; must divide XLEN; 1, 2 or 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  abort in-flight op (branch mispredict/trap)
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1  in  XLEN  rs1 value
- src2  in  XLEN  rs2 value
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  result
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst sampled on the clk rising edge. Result: state=IDLE, out_valid=0, out_result=0, busy=0, in_ready=1, all datapath regs 0. Reset mid-operation discards the op with no output.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: in_valid&&in_ready at edge T. in_ready=1 only in IDLE. Operands and op are latched at T; later input changes are ignored.
- IDLE→MUL: op[2]=0.
- IDLE→DIV: op[2]=1, normal case.
- IDLE→DONE: op[2]=1, special case. Result is registered at T, so out_valid=1 at T+1.
- MUL:
  - Operands sign- or zero-extended to XLEN+1 per op (MULH s×s, MULHSU s×u, MULHU/MUL u×u).
  - 2·XLEN product is pipelined over MUL_STAGES cycles; out_valid rises at T+MUL_STAGES.
  - MUL returns product[XLEN-1:0]; the others return product[2XLEN-1:XLEN].
- DIV:
  - Signed ops use |src1|, |src2|.
  - Restoring shift-subtract retires DIV_BITS quotient bits per cycle; iteration counter counts XLEN/DIV_BITS cycles.
  - Then FIX (1 cycle): negate quotient if signs differ; negate remainder if dividend negative (signed ops only).
  - Then DONE. out_valid rises at T+XLEN/DIV_BITS+1.
- Special cases (DONE directly):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → src1.
  - Signed overflow (src1=1<<(XLEN-1), src2=−1): DIV → src1; REM → 0.
- DONE: out_valid=1 and out_result stable until out_valid&&out_ready, then → IDLE. in_ready rises the cycle after the handshake; no same-cycle accept.
- Flush:
  - In any non-IDLE state: next state IDLE, out_valid=0 next cycle, result dropped.
  - Flush with in_valid in IDLE: request not accepted.
  - Flush coincident with the out_ready handshake: handshake completes; the result counts as consumed.
- rst has priority over flush; flush has priority over all transitions.
- out_result = 0 whenever out_valid=0.
- Parameter check: elaboration $error if XLEN%DIV_BITS≠0 or MUL_STAGES<1.

Test Plan:
- Defaults, MULH src1=0x80000000, src2=0x80000000, out_ready=1 → out_valid at T+2, result 0x40000000. MUL same operands → 0x00000000. MULHSU src1=0xFFFFFFFF, src2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV src1=−7 (0xFFFFFFF9), src2=2 → out_valid at T+33, result 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF at T+1. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0 at T+1.
- DIV 1000/3 issued, flush at T+10 → busy=0 and in_ready=1 at T+11, no out_valid. Next MUL 6×7 → 42 at its T+2.
- DIVU 9/3 with out_ready=0 for 5 cycles after out_valid → result 3 held stable, in_ready=0. Release out_ready → IDLE next cycle.
- XLEN=64, DIV_BITS=4: DIVU 2^63/3 → 0x2AAAAAAAAAAAAAAA at T+17. Assert rst mid-divide → outputs 0 next cycle.
